// File: rtl/linked_list_fifo_reader_pkg.sv
// Shared types and helpers for the linked-list multi-FIFO read engine:
// index width sizing, one-hot decode and the rotating priority search.
package linked_list_fifo_reader_pkg;

    localparam int MAX_FIFOS = 32;

    typedef logic [MAX_FIFOS-1:0] fifo_vec_t;

    // A single FIFO still needs a one-bit index on out_id.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int onehot_to_idx(input fifo_vec_t oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_FIFOS; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

    // First set bit of req at or above ptr, wrapping at n; result is one-hot or zero.
    function automatic fifo_vec_t rr_pick(input fifo_vec_t req, input int ptr, input int n);
        fifo_vec_t grant;
        int        idx;
        logic      found;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_FIFOS; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/linked_list_fifo_reader_if.sv
// Bundle between the multi-FIFO read side, the reader engine and the downstream consumer.
interface linked_list_fifo_reader_if
    import linked_list_fifo_reader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_FIFOS = 2,
    parameter int ID_WIDTH  = id_width(NUM_FIFOS)
);
    logic [NUM_FIFOS-1:0] empty;
    logic [WIDTH-1:0]     fifo_data;
    logic                 push_busy;
    logic [NUM_FIFOS-1:0] enable;
    logic [NUM_FIFOS-1:0] pop;

    // A word transfers on any rising edge where out_valid && out_ready; while
    // out_valid is high and out_ready low, out_data/out_id stay frozen.
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [ID_WIDTH-1:0]  out_id;

    modport master (
        input  empty, fifo_data, push_busy, enable, out_ready,
        output pop, out_valid, out_data, out_id
    );

    modport slave (
        output empty, fifo_data, push_busy, enable, out_ready,
        input  pop, out_valid, out_data, out_id
    );

endinterface

// File: rtl/linked_list_fifo_reader_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr and
// moves rr_ptr past the winner only when the grant is actually used.
module linked_list_fifo_reader_rr_arbiter
    import linked_list_fifo_reader_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = id_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] rr_ptr;

    always_comb begin
        grant     = N'(rr_pick(fifo_vec_t'(req), int'(rr_ptr), N));
        grant_idx = IW'(onehot_to_idx(fifo_vec_t'(grant)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/linked_list_fifo_reader.sv
// Read-side engine for the linked-list multi-FIFO: pops one eligible FIFO per
// cycle round-robin into a single output register drained by valid/ready.
module linked_list_fifo_reader
    import linked_list_fifo_reader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_FIFOS = 2,
    parameter int ID_WIDTH  = id_width(NUM_FIFOS)
) (
    input  logic                      clk,
    input  logic                      rst,
    linked_list_fifo_reader_if.master bus
);

    logic [NUM_FIFOS-1:0] elig;
    logic [NUM_FIFOS-1:0] grant;
    logic [ID_WIDTH-1:0]  grant_idx;
    logic                 can_load;
    logic                 advance;

    logic                 out_valid_q;
    logic [WIDTH-1:0]     out_data_q;
    logic [ID_WIDTH-1:0]  out_id_q;

    // can_load looks at out_ready directly, so a full register can be drained
    // and refilled in the same cycle without a bubble.
    always_comb begin
        elig     = ~bus.empty & bus.enable;
        can_load = ~out_valid_q | bus.out_ready;
        advance  = (|elig) & can_load & ~bus.push_busy & ~rst;
    end

    linked_list_fifo_reader_rr_arbiter #(
        .N  (NUM_FIFOS),
        .IW (ID_WIDTH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (elig),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign bus.pop = advance ? grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else if (advance) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.fifo_data;
            out_id_q    <= grant_idx;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_linked_list_fifo_reader.sv
// Bench for linked_list_fifo_reader with four FIFOs: table vectors, hand
// sequences for the multi-cycle corners, and randomized traffic vs a queue model.
module tb_linked_list_fifo_reader;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    typedef struct {
        logic [N-1:0]  emp;
        logic [W-1:0]  d;
        logic [N-1:0]  exp_pop;
        logic [IW-1:0] exp_id;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    linked_list_fifo_reader_if #(.WIDTH(W), .NUM_FIFOS(N), .ID_WIDTH(IW)) bus ();

    linked_list_fifo_reader #(.WIDTH(W), .NUM_FIFOS(N), .ID_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: what the output register should hold and where the search starts.
    int           m_ptr;
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_id;
    logic [N-1:0] last_pop;

    logic [W-1:0]    fq[N][$];
    logic [IW+W-1:0] exp_q[$];
    vec_t            tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_search(input logic [N-1:0] e, input int p);
        for (int k = 0; k < N; k++) begin
            if (e[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One clock: drive inputs at negedge, check pop, clock the model, check the register.
    task automatic step(input bit r, input logic [N-1:0] emp, input logic [N-1:0] en,
                        input bit busy, input bit rdy, input logic [W-1:0] d, input bit use_q);
        logic [N-1:0] exp_pop;
        int g;
        @(negedge clk);
        if (use_q) begin
            for (int i = 0; i < N; i++) emp[i] = (fq[i].size() == 0);
        end
        g = -1;
        if (!r && ((~emp & en) != 0) && (!m_valid || rdy) && !busy)
            g = rr_search(~emp & en, m_ptr);
        exp_pop = (g >= 0) ? N'(1 << g) : '0;
        if (use_q && g >= 0) d = fq[g][0];
        rst           = r;
        bus.empty     = emp;
        bus.enable    = en;
        bus.push_busy = busy;
        bus.out_ready = rdy;
        bus.fifo_data = d;
        #1;
        last_pop = bus.pop;
        check("pop", 32'(bus.pop), 32'(exp_pop));
        check("pop_of_empty", 32'(bus.pop & emp), 32'd0);
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_data = '0; m_id = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_valid = 1; m_data = d; m_id = g; m_ptr = (g + 1) % N;
            if (use_q) fq[g].delete(0);
        end else if (rdy) begin
            m_valid = 0;
        end
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid || r) begin
            check("out_data", 32'(bus.out_data), 32'(m_data));
            check("out_id", 32'(bus.out_id), 32'(m_id));
        end
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) step(1, '0, '1, 0, 1, 8'h55, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.empty = '1; bus.enable = '1; bus.push_busy = 1'b0;
        bus.out_ready = 1'b1; bus.fifo_data = '0;
        m_ptr = 0; m_valid = 0; m_data = '0; m_id = 0;

        // Reset held three cycles with traffic present, then first grant is FIFO 0.
        do_reset(3);
        check("reset_valid", 32'(bus.out_valid), 32'd0);
        step(0, 4'b0000, 4'hF, 0, 1, 8'h10, 0);
        check("first_pop", 32'(last_pop), 32'h1);

        // Round-robin fairness table.
        for (int k = 0; k < 8; k++) begin
            tbl[k].emp     = 4'b0000;
            tbl[k].d       = 8'h20 + 8'(k);
            tbl[k].exp_pop = 4'(1 << (k % 4));
            tbl[k].exp_id  = 2'(k % 4);
        end
        do_reset(1);
        for (int k = 0; k < 8; k++) begin
            step(0, tbl[k].emp, 4'hF, 0, 1, tbl[k].d, 0);
            check("rr_pop", 32'(last_pop), 32'(tbl[k].exp_pop));
            check("rr_valid", 32'(bus.out_valid), 32'd1);
            check("rr_id", 32'(bus.out_id), 32'(tbl[k].exp_id));
            check("rr_data", 32'(bus.out_data), 32'(tbl[k].d));
        end

        // Sparse and wrap: park rr_ptr at 3, then only FIFOs 0 and 2 are non-empty.
        do_reset(1);
        step(0, 4'b1011, 4'hF, 0, 1, 8'h31, 0);
        check("wrap_setup", 32'(last_pop), 32'h4);
        step(0, 4'b1010, 4'hF, 0, 1, 8'h32, 0);
        check("wrap_pop0", 32'(last_pop), 32'h1);
        step(0, 4'b1010, 4'hF, 0, 1, 8'h33, 0);
        check("wrap_pop2", 32'(last_pop), 32'h4);
        step(0, 4'b1010, 4'hF, 0, 1, 8'h34, 0);
        check("wrap_pop0b", 32'(last_pop), 32'h1);
        for (int i = 0; i < 2; i++) begin
            step(0, 4'b1010, 4'b1011, 0, 1, 8'h35, 0);
            check("mask_pop0", 32'(last_pop), 32'h1);
        end

        // Backpressure: A5 held for five stalled cycles, then drain and refill together.
        do_reset(1);
        step(0, 4'b1110, 4'hF, 0, 1, 8'hA5, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 4'b0000, 4'hF, 0, 0, 8'(i), 0);
            check("bp_pop", 32'(last_pop), 32'd0);
            check("bp_hold", 32'(bus.out_data), 32'hA5);
        end
        step(0, 4'b0000, 4'hF, 0, 1, 8'h3C, 0);
        check("bp_refill_pop", 32'(last_pop), 32'h2);
        check("bp_refill_data", 32'(bus.out_data), 32'h3C);

        // Push collision: pointer is at 2 and must still be there afterwards.
        for (int i = 0; i < 3; i++) begin
            step(0, 4'b0000, 4'hF, 1, 1, 8'h44, 0);
            check("busy_pop", 32'(last_pop), 32'd0);
        end
        check("busy_drained", 32'(bus.out_valid), 32'd0);
        step(0, 4'b0000, 4'hF, 0, 1, 8'h45, 0);
        check("busy_resume", 32'(last_pop), 32'h4);

        // End to end against a queue-backed multi-FIFO.
        do_reset(1);
        fq[0].push_back(8'h11); fq[0].push_back(8'h22); fq[1].push_back(8'h33);
        exp_q.push_back({2'd0, 8'h11}); exp_q.push_back({2'd1, 8'h33}); exp_q.push_back({2'd0, 8'h22});
        for (int i = 0; i < 8; i++) begin
            step(0, '1, 4'b0011, 0, 1, 8'h00, 1);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) check("e2e_extra", {22'd0, bus.out_id, bus.out_data}, 32'hFFFF);
                else check("e2e_word", {22'd0, bus.out_id, bus.out_data}, 32'(exp_q.pop_front()));
            end
        end
        check("e2e_left", 32'(exp_q.size()), 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0, 8'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
